// File: rtl/fpmul_pkg.sv
// Shared constants, register map and FSM encoding for the memory-mapped binary32 multiplier.
package fpmul_pkg;

  localparam logic [1:0] OFF_OPA  = 2'd0;
  localparam logic [1:0] OFF_OPB  = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_RES  = 2'd3;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_BUSY = 1;
  localparam int unsigned STAT_OVF  = 2;
  localparam int unsigned STAT_UNF  = 3;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned EXP_W   = 8;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StNorm
  } state_e;

  // Signed zero or signed infinity.
  function automatic logic [31:0] pack_special(input logic sign, input logic inf);
    return inf ? (POS_INF | {sign, 31'b0}) : {sign, 31'b0};
  endfunction

endpackage

// File: rtl/fp_mul_core.sv
// Iterative binary32 multiplier: 24-step shift-add mantissa product, then normalize and pack.
module fp_mul_core
  import fpmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic        o_ovf,
  output logic        o_unf
);

  state_e      r_state, w_state_d;
  logic [4:0]  r_count, w_count_d;
  logic [47:0] r_acc, w_acc_d;
  logic [47:0] r_mcand, w_mcand_d;
  logic [23:0] r_mplier, w_mplier_d;
  logic        r_sign, w_sign_d;
  logic [9:0]  r_esum, w_esum_d;
  logic        r_zero, w_zero_d;
  logic        r_inf, w_inf_d;

  logic [7:0]  w_ea, w_eb;
  logic [9:0]  w_exp;
  logic [22:0] w_mant;

  assign w_ea = i_a[MANT_W +: EXP_W];
  assign w_eb = i_b[MANT_W +: EXP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_esum   <= '0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_sign   <= w_sign_d;
      r_esum   <= w_esum_d;
      r_zero   <= w_zero_d;
      r_inf    <= w_inf_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_sign_d   = r_sign;
    w_esum_d   = r_esum;
    w_zero_d   = r_zero;
    w_inf_d    = r_inf;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d  = StMul;
          w_count_d  = '0;
          w_acc_d    = '0;
          w_mcand_d  = {24'b0, 1'b1, i_a[MANT_W-1:0]};
          w_mplier_d = {1'b1, i_b[MANT_W-1:0]};
          w_sign_d   = i_a[31] ^ i_b[31];
          w_esum_d   = {2'b0, w_ea} + {2'b0, w_eb};
          w_zero_d   = (w_ea == 8'd0) || (w_eb == 8'd0);
          w_inf_d    = (w_ea == 8'(EXP_MAX)) || (w_eb == 8'(EXP_MAX));
        end
      end
      StMul: begin
        if (r_mplier[0]) w_acc_d = r_acc + r_mcand;
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_count_d  = r_count + 5'd1;
        if (r_count == 5'd23) w_state_d = StNorm;
      end
      StNorm:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = (r_state == StNorm);

  // Product of two [1,2) mantissas lies in [1,4); bit 47 set means one extra exponent step.
  always_comb begin
    w_exp    = r_esum - 10'(BIAS) + {9'b0, r_acc[47]};
    w_mant   = r_acc[47] ? r_acc[46:24] : r_acc[45:23];
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    o_result = {r_sign, w_exp[7:0], w_mant};
    if (r_zero) begin
      o_result = pack_special(r_sign, 1'b0);
    end else if (r_inf) begin
      o_result = pack_special(r_sign, 1'b1);
      o_ovf    = 1'b1;
    end else if ($signed(w_exp) >= $signed(10'(EXP_MAX))) begin
      o_result = pack_special(r_sign, 1'b1);
      o_ovf    = 1'b1;
    end else if ($signed(w_exp) <= $signed(10'd0)) begin
      o_result = pack_special(r_sign, 1'b0);
      o_unf    = 1'b1;
    end
  end

endmodule

// File: rtl/fpmul_mmio.sv
// Bus-facing register file for the iterative multiplier: operand/result registers and status.
module fpmul_mmio
  import fpmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  logic [31:0] r_opa, r_opb, r_result;
  logic        r_done, r_ovf, r_unf;

  logic        w_busy, w_core_done, w_core_ovf, w_core_unf, w_go;
  logic [31:0] w_core_result;

  // Operand writes and go are locked out for the whole multiply.
  assign w_go = we && (a == OFF_CTRL) && wd[0] && !w_busy;

  fp_mul_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_go),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .o_busy   (w_busy),
    .o_done   (w_core_done),
    .o_result (w_core_result),
    .o_ovf    (w_core_ovf),
    .o_unf    (w_core_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (we && !w_busy && (a == OFF_OPA)) r_opa <= wd;
      if (we && !w_busy && (a == OFF_OPB)) r_opb <= wd;
      if (w_go) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
      end else if (w_core_done) begin
        r_result <= w_core_result;
        r_done   <= 1'b1;
        r_ovf    <= w_core_ovf;
        r_unf    <= w_core_unf;
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (a)
      OFF_OPA: rd = r_opa;
      OFF_OPB: rd = r_opb;
      OFF_CTRL: begin
        rd[STAT_DONE] = r_done;
        rd[STAT_BUSY] = w_busy;
        rd[STAT_OVF]  = r_ovf;
        rd[STAT_UNF]  = r_unf;
      end
      OFF_RES: rd = r_result;
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fpmul_mmio.sv
// Directed bench for fpmul_mmio: expected products queued at go, compared when done is seen.
module tb_fpmul_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  a = 2'd0;
  logic [31:0] wd = '0;
  logic [31:0] rd;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] stat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  fpmul_mmio dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [31:0] d);
    a = off;
    #1;
    d = rd;
  endtask

  // Drive at the falling edge, sampled on the next rising edge, return 1 time unit after it.
  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    a  = off;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input bit load, input logic [31:0] res, input bit ovf, input bit unf,
                        input bit meddle, input logic [31:0] prev_res);
    logic [31:0] d;
    int n;
    bit done;
    exp_t e;
    if (load) begin
      bus_write(2'd0, opa);
      bus_write(2'd1, opb);
    end
    sb_q.push_back('{res, {28'b0, unf, ovf, 2'b01}, tag});
    bus_write(2'd2, 32'h1);
    rd_reg(2'd2, d);
    check({tag, "_busy"}, d, 32'h2);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      if (meddle && n == 5) begin
        bus_write(2'd0, 32'h1234_5678);
        bus_write(2'd2, 32'h1);
        n += 2;
        rd_reg(2'd0, d);
        check({tag, "_opa_locked"}, d, opa);
        rd_reg(2'd3, d);
        check({tag, "_res_held"}, d, prev_res);
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
      rd_reg(2'd2, d);
      done = d[0];
    end
    check({tag, "_latency"}, 32'(n), 32'd25);
    e = sb_q.pop_front();
    rd_reg(2'd3, d);
    check({e.tag, "_result"}, d, e.res);
    rd_reg(2'd2, d);
    check({e.tag, "_status"}, d, e.stat);
  endtask

  initial begin
    logic [31:0] d;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      check($sformatf("reset_reg%0d", i), d, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_2x3", 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 1'b0, 1'b0,
           1'b0, 32'h0);
    run_op("back2back", 32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40C0_0000, 1'b0, 1'b0,
           1'b0, 32'h0);

    bus_write(2'd3, 32'hDEAD_BEEF);
    rd_reg(2'd3, d);
    check("res_ro", d, 32'h40C0_0000);
    rd_reg(2'd0, d);
    check("opa_rb", d, 32'h4000_0000);
    rd_reg(2'd1, d);
    check("opb_rb", d, 32'h4040_0000);

    run_op("mul_1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h4010_0000, 1'b0, 1'b0,
           1'b1, 32'h40C0_0000);
    run_op("neg_one", 32'hBF80_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 1'b0, 1'b0,
           1'b0, 32'h0);
    run_op("neg_zero", 32'h8000_0000, 32'h4000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0,
           1'b0, 32'h0);
    run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 1'b1, 32'h7F80_0000, 1'b1, 1'b0,
           1'b0, 32'h0);
    run_op("unf", 32'h0080_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1,
           1'b0, 32'h0);

    // Abort an operation at E10 with an asynchronous reset.
    bus_write(2'd0, 32'h4000_0000);
    bus_write(2'd1, 32'h4040_0000);
    bus_write(2'd2, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      check($sformatf("abort_reg%0d", i), d, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h4010_0000, 1'b0, 1'b0,
           1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
